// File: rtl/sys_defs.sv
// Shared processor definitions: branch-mask types, physical register tags,
// decoded control word, and the multiplier pipeline stage record.

`ifndef BR_STACK_SIZE
`define BR_STACK_SIZE 4
`endif

package sys_defs;

  // Datapath width the shared stage record is built for.
  localparam int SYS_XLEN       = 64;
  // Number of in-flight branches tracked by the branch stack.
  localparam int BR_STACK_SIZE  = `BR_STACK_SIZE;
  // Default depth of the pipelined multiplier.
  localparam int MULT_STAGES    = 4;
  // Physical register file has 64 entries.
  localparam int PHYS_REG_BITS  = 6;

  typedef logic [BR_STACK_SIZE-1:0]         B_MASK;
  typedef logic [$clog2(BR_STACK_SIZE)-1:0] BS_PTR;
  typedef logic [PHYS_REG_BITS-1:0]         PHYS_REG;

  typedef enum logic [4:0] {
    ALU_ADDQ   = 5'h00,
    ALU_SUBQ   = 5'h01,
    ALU_AND    = 5'h02,
    ALU_BIS    = 5'h03,
    ALU_XOR    = 5'h04,
    ALU_SLL    = 5'h05,
    ALU_SRL    = 5'h06,
    ALU_SRA    = 5'h07,
    ALU_CMPEQ  = 5'h08,
    ALU_CMPLT  = 5'h09,
    ALU_CMPULT = 5'h0a,
    ALU_MULQ   = 5'h0b,
    ALU_UMULH  = 5'h0c
  } alu_func_t;

  // Decoded control word as seen by the functional units; the multiplier
  // only looks at the ALU function.
  typedef struct packed {
    alu_func_t alu_func;
  } DE_control_t;

  // One multiplier pipeline stage: bookkeeping plus the running shift-add
  // state. mcand is pre-shifted left and mplier pre-shifted right so every
  // stage always consumes the low bits of mplier.
  typedef struct packed {
    logic                    valid;
    PHYS_REG                 tag;
    B_MASK                   bmask;
    alu_func_t               func;
    logic [2*SYS_XLEN-1:0]   psum;
    logic [2*SYS_XLEN-1:0]   mcand;
    logic [SYS_XLEN-1:0]     mplier;
  } mult_stage_t;

  // Apply a branch resolution to one stage: a mispredict kills dependent
  // ops, a correct prediction just retires the dependency bit.
  function automatic mult_stage_t br_update(input mult_stage_t s,
                                            input logic        done,
                                            input logic        wrong,
                                            input BS_PTR       ptr);
    mult_stage_t r;
    r = s;
    if (done && s.bmask[ptr]) begin
      if (wrong) begin
        r.valid = 1'b0;
      end else begin
        r.bmask[ptr] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_mult_fu_stage.sv
// Combinational shift-add step: folds BITS multiplier bits into the running
// partial sum and hands the re-aligned operands to the next stage.

module mult_stage #(
  parameter int XLEN = 64,
  parameter int BITS = 16
) (
  input  logic [2*XLEN-1:0] sum_i,
  input  logic [2*XLEN-1:0] mcand_i,
  input  logic [XLEN-1:0]   mplier_i,
  output logic [2*XLEN-1:0] sum_o,
  output logic [2*XLEN-1:0] mcand_o,
  output logic [XLEN-1:0]   mplier_o
);

  logic [2*XLEN-1:0] acc;

  // Add the multiplicand, shifted by bit position, for each set multiplier bit.
  always_comb begin
    acc = sum_i;
    for (int j = 0; j < BITS; j++) begin
      if (mplier_i[j]) begin
        acc = acc + (mcand_i << j);
      end
    end
  end

  assign sum_o    = acc;
  assign mcand_o  = mcand_i << BITS;
  assign mplier_o = mplier_i >> BITS;

endmodule

// File: rtl/pipe_mult_fu.sv
// Pipelined unsigned multiplier functional unit. An op walks through STAGES
// registered shift-add stages; the whole pipe freezes while the CDB refuses
// the output, and branch resolutions squash or clean ops in every stage.
// XLEN is expected to equal sys_defs::SYS_XLEN because the stage record is
// shared through the package.

module pipe_mult_fu
  import sys_defs::*;
#(
  parameter int STAGES   = MULT_STAGES,
  parameter int XLEN     = 64,
  parameter int BR_DEPTH = `BR_STACK_SIZE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fus_en,
  input  logic [XLEN-1:0]     fus_opA,
  input  logic [XLEN-1:0]     fus_opB,
  input  PHYS_REG             fus_tagDest,
  input  DE_control_t         fus_control,
  input  logic [BR_DEPTH-1:0] fus_bmask,
  input  logic                br_fub_done,
  input  logic                br_fub_pred_wrong,
  input  BS_PTR               br_fub_bs_ptr,
  input  logic                cdb_stall,
  output logic                mult_ready,
  output logic                mult_done,
  output PHYS_REG             mult_tagDest,
  output logic [XLEN-1:0]     mult_result,
  output logic [BR_DEPTH-1:0] mult_bmask
);

  localparam int BITS = XLEN / STAGES;

  mult_stage_t issue_s;
  mult_stage_t stage_q [STAGES];
  mult_stage_t out_s;

  // Package the incoming issue as a stage record with a zero partial sum.
  always_comb begin
    issue_s        = '0;
    issue_s.valid  = fus_en;
    issue_s.tag    = fus_tagDest;
    issue_s.bmask  = fus_bmask;
    issue_s.func   = fus_control.alu_func;
    issue_s.mcand  = {{XLEN{1'b0}}, fus_opA};
    issue_s.mplier = fus_opB;
  end

  // The pipe can move unless the finished op is being held off the CDB.
  assign mult_ready = ~(cdb_stall & out_s.valid);

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      mult_stage_t       in_s;
      mult_stage_t       step_s;
      mult_stage_t       d_s;
      mult_stage_t       q_s;
      logic [2*XLEN-1:0] sum_w;
      logic [2*XLEN-1:0] mcand_w;
      logic [XLEN-1:0]   mplier_w;

      if (gi == 0) begin : g_head
        assign in_s = issue_s;
      end else begin : g_body
        assign in_s = stage_q[gi-1];
      end

      mult_stage #(
        .XLEN (XLEN),
        .BITS (BITS)
      ) u_step (
        .sum_i    (in_s.psum),
        .mcand_i  (in_s.mcand),
        .mplier_i (in_s.mplier),
        .sum_o    (sum_w),
        .mcand_o  (mcand_w),
        .mplier_o (mplier_w)
      );

      // Record produced by advancing the upstream op through this step.
      always_comb begin
        step_s        = in_s;
        step_s.psum   = sum_w;
        step_s.mcand  = mcand_w;
        step_s.mplier = mplier_w;
      end

      // Advance when ready, otherwise hold; branch resolution applies in both cases.
      always_comb begin
        d_s = br_update(mult_ready ? step_s : q_s,
                        br_fub_done, br_fub_pred_wrong, br_fub_bs_ptr);
      end

      // Stage register; reset wipes the whole record so outputs read zero.
      always_ff @(posedge clock) begin
        if (reset) begin
          q_s <= '0;
        end else begin
          q_s <= d_s;
        end
      end

      assign stage_q[gi] = q_s;
    end
  endgenerate

  assign out_s        = stage_q[STAGES-1];
  assign mult_done    = out_s.valid;
  assign mult_tagDest = out_s.tag;
  assign mult_bmask   = out_s.bmask;
  assign mult_result  = (out_s.func == ALU_UMULH) ? out_s.psum[2*XLEN-1:XLEN]
                                                  : out_s.psum[XLEN-1:0];

endmodule

// File: tb/tb_pipe_mult_fu.sv
// Directed bench for pipe_mult_fu with an in-order scoreboard of expected results.

module tb_pipe_mult_fu;
  import sys_defs::*;

  logic        clk;
  logic        reset;
  logic        fus_en;
  logic [63:0] fus_opA;
  logic [63:0] fus_opB;
  PHYS_REG     fus_tagDest;
  DE_control_t fus_control;
  logic [3:0]  fus_bmask;
  logic        br_fub_done;
  logic        br_fub_pred_wrong;
  BS_PTR       br_fub_bs_ptr;
  logic        cdb_stall;
  logic        mult_ready;
  logic        mult_done;
  PHYS_REG     mult_tagDest;
  logic [63:0] mult_result;
  logic [3:0]  mult_bmask;

  typedef struct {
    logic [5:0]  tag;
    logic [63:0] res;
    logic [3:0]  bmask;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   seen;

  pipe_mult_fu dut (
    .clock             (clk),
    .reset             (reset),
    .fus_en            (fus_en),
    .fus_opA           (fus_opA),
    .fus_opB           (fus_opB),
    .fus_tagDest       (fus_tagDest),
    .fus_control       (fus_control),
    .fus_bmask         (fus_bmask),
    .br_fub_done       (br_fub_done),
    .br_fub_pred_wrong (br_fub_pred_wrong),
    .br_fub_bs_ptr     (br_fub_bs_ptr),
    .cdb_stall         (cdb_stall),
    .mult_ready        (mult_ready),
    .mult_done         (mult_done),
    .mult_tagDest      (mult_tagDest),
    .mult_result       (mult_result),
    .mult_bmask        (mult_bmask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard-aware clock step: compare an accepted output, record a
  // newly issued op, apply branch resolution, then cross the next edge.
  task automatic cycle();
    exp_t        e;
    logic [127:0] p;
    if (reset) begin
      @(posedge clk);
      #1;
      q.delete();
      return;
    end
    if (mult_done === 1'b1 && cdb_stall === 1'b0) begin
      if (q.size() == 0) begin
        chk("spurious_done", mult_done, 1'b0);
      end else begin
        e = q.pop_front();
        chk("tag", mult_tagDest, e.tag);
        chk("result", mult_result, e.res);
        chk("bmask", mult_bmask, e.bmask);
        $display("out tag=%0d result=%0h bmask=%b", mult_tagDest, mult_result, mult_bmask);
      end
    end
    if (fus_en && !cdb_stall) begin
      p = {64'b0, fus_opA} * {64'b0, fus_opB};
      e.tag   = fus_tagDest;
      e.res   = (fus_control.alu_func == ALU_UMULH) ? p[127:64] : p[63:0];
      e.bmask = fus_bmask;
      q.push_back(e);
      $display("issue tag=%0d a=%0h b=%0h bmask=%b", fus_tagDest, fus_opA, fus_opB, fus_bmask);
    end
    if (br_fub_done) begin
      exp_t nq[$];
      foreach (q[i]) begin
        if (q[i].bmask[br_fub_bs_ptr]) begin
          if (!br_fub_pred_wrong) begin
            e = q[i];
            e.bmask[br_fub_bs_ptr] = 1'b0;
            nq.push_back(e);
          end
        end else begin
          nq.push_back(q[i]);
        end
      end
      q = nq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input alu_func_t f, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] t, input logic [3:0] bm);
    fus_en               = 1'b1;
    fus_control.alu_func = f;
    fus_opA              = a;
    fus_opB              = b;
    fus_tagDest          = t;
    fus_bmask            = bm;
    cycle();
    fus_en               = 1'b0;
  endtask

  task automatic branch(input BS_PTR ptr, input logic wrong);
    br_fub_done       = 1'b1;
    br_fub_pred_wrong = wrong;
    br_fub_bs_ptr     = ptr;
    cycle();
    br_fub_done       = 1'b0;
    br_fub_pred_wrong = 1'b0;
  endtask

  // Run until the scoreboard empties (bounded), then idle a few cycles so
  // any leftover output is caught as spurious. Counts accepted outputs.
  task automatic drain(output int n_done);
    int budget;
    budget = 0;
    n_done = 0;
    while (q.size() > 0 && budget < 30) begin
      if (mult_done === 1'b1) n_done++;
      cycle();
      budget++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (6) begin
      if (mult_done === 1'b1) n_done++;
      cycle();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (mult_done !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    chk("wait_done", mult_done, 1'b1);
  endtask

  initial begin
    reset             = 1'b1;
    fus_en            = 1'b0;
    fus_opA           = '0;
    fus_opB           = '0;
    fus_tagDest       = '0;
    fus_control       = '0;
    fus_bmask         = '0;
    br_fub_done       = 1'b0;
    br_fub_pred_wrong = 1'b0;
    br_fub_bs_ptr     = '0;
    cdb_stall         = 1'b0;

    // Reset state
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_done", mult_done, 1'b0);
    chk("rst_ready", mult_ready, 1'b1);
    chk("rst_tag", mult_tagDest, 6'd0);
    chk("rst_result", mult_result, 64'd0);
    chk("rst_bmask", mult_bmask, 4'd0);

    // MULQ 3*5 tag 7: done exactly on the fourth edge counting the issue edge
    issue(ALU_MULQ, 64'd3, 64'd5, 6'd7, 4'b0000);
    chk("lat1", mult_done, 1'b0);
    cycle();
    chk("lat2", mult_done, 1'b0);
    cycle();
    chk("lat3", mult_done, 1'b0);
    cycle();
    chk("lat4_done", mult_done, 1'b1);
    chk("lat4_result", mult_result, 64'd15);
    chk("lat4_tag", mult_tagDest, 6'd7);
    drain(seen);

    // UMULH all-ones * 2 -> 1
    issue(ALU_UMULH, 64'hffff_ffff_ffff_ffff, 64'd2, 6'd8, 4'b0000);
    wait_done();
    chk("umulh", mult_result, 64'd1);
    drain(seen);

    // Four back-to-back MULQ ops -> four consecutive done cycles in order
    issue(ALU_MULQ, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 6'd10, 4'b0000);
    issue(ALU_MULQ, 64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff, 6'd11, 4'b0000);
    issue(ALU_MULQ, {32'd0, $urandom}, {32'd0, $urandom}, 6'd12, 4'b0000);
    issue(ALU_MULQ, 64'd0, 64'hdead_beef, 6'd13, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      chk("b2b_done", mult_done, 1'b1);
      cycle();
    end
    drain(seen);
    chk("b2b_tail", seen, 0);

    // Mispredict squashes the bmask-bit-1 op; the bit-0 op survives
    issue(ALU_MULQ, 64'd100, 64'd7, 6'd14, 4'b0010);
    issue(ALU_MULQ, 64'd9, 64'd9, 6'd15, 4'b0001);
    branch(2'd1, 1'b1);
    drain(seen);
    chk("squash_count", seen, 1);

    // Correct prediction clears the dependency bit
    issue(ALU_MULQ, 64'd123, 64'd456, 6'd16, 4'b0010);
    branch(2'd1, 1'b0);
    drain(seen);
    chk("clear_count", seen, 1);

    // Unrelated mispredict leaves the op alone
    issue(ALU_UMULH, 64'h8000_0000_0000_0000, 64'd6, 6'd17, 4'b0001);
    branch(2'd2, 1'b1);
    drain(seen);
    chk("unrelated_count", seen, 1);

    // CDB stall freezes the pipe and holds outputs
    issue(ALU_MULQ, 64'd21, 64'd2, 6'd20, 4'b0000);
    issue(ALU_MULQ, 64'd33, 64'd3, 6'd21, 4'b0000);
    wait_done();
    cdb_stall = 1'b1;
    #1;
    chk("stall_ready", mult_ready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold_done", mult_done, 1'b1);
      chk("hold_ready", mult_ready, 1'b0);
      chk("hold_tag", mult_tagDest, 6'd20);
      chk("hold_result", mult_result, 64'd42);
    end
    cdb_stall = 1'b0;
    cycle();
    chk("next_done", mult_done, 1'b1);
    chk("next_tag", mult_tagDest, 6'd21);
    drain(seen);

    // Squash of the stalled output op drops done and releases the freeze
    issue(ALU_MULQ, 64'd5, 64'd5, 6'd22, 4'b0100);
    wait_done();
    cdb_stall = 1'b1;
    cycle();
    chk("stall2_done", mult_done, 1'b1);
    branch(2'd2, 1'b1);
    chk("squash_stall_done", mult_done, 1'b0);
    chk("squash_stall_ready", mult_ready, 1'b1);
    cdb_stall = 1'b0;
    drain(seen);
    chk("squash_stall_count", seen, 0);

    // Reset with three ops in flight discards them all
    issue(ALU_MULQ, 64'd2, 64'd3, 6'd30, 4'b0000);
    issue(ALU_MULQ, 64'd4, 64'd5, 6'd31, 4'b0000);
    issue(ALU_MULQ, 64'd6, 64'd7, 6'd32, 4'b0000);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("post_rst_done", mult_done, 1'b0);
      chk("post_rst_ready", mult_ready, 1'b1);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
